// File: rtl/fifo_stream_reader.sv
// Read-side drain stage for the synchronous FIFO. It absorbs the FIFO's one-cycle read
// latency in a 2-entry skid buffer and frames the words into fixed-length valid/ready packets.
module fifo_stream_reader #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] pkt_count,
  output logic             busy
);

  localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic [1:0]        occ;
  logic              inflight;
  logic              head;
  logic              tail;
  logic [WIDTH-1:0]  entry [2];
  logic [BEAT_W-1:0] beat;

  logic              pop;
  logic [1:0]        level_after_pop;

  // Read whenever the word it returns is guaranteed a buffer slot. Counting this cycle's
  // pop is the combinational m_ready path that keeps one word per clock flowing.
  always_comb begin
    pop             = m_valid && m_ready;
    level_after_pop = occ + {1'b0, inflight} - {1'b0, pop};
    fifo_rd_en      = !reset && !fifo_empty && (level_after_pop < 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= '0;
      inflight  <= 1'b0;
      head      <= 1'b0;
      tail      <= 1'b0;
      // NOTE: the two buffer entries are reset so m_data reads 0 out of reset; a deep
      // memory would normally be left unreset, but here it is only two flops.
      entry[0]  <= '0;
      entry[1]  <= '0;
      beat      <= '0;
      pkt_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= level_after_pop;

      // The FIFO's rdata is valid exactly one cycle after the strobe.
      if (inflight) begin
        entry[tail] <= fifo_rdata;
        tail        <= ~tail;
      end

      if (pop) begin
        head <= ~head;
        if (beat == LAST_BEAT) begin
          beat      <= '0;
          pkt_count <= pkt_count + CNT_W'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
      end
    end
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = entry[head];
  assign m_last  = (beat == LAST_BEAT);
  assign busy    = (occ != 2'd0) || inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural synchronous FIFO feeds the DUT, and a
// scoreboard queue filled at FIFO-write time is popped on every accepted output beat.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int WIDTH     = 8;
  localparam int PKT_LEN   = 4;
  localparam int CNT_W     = 16;
  localparam int FIFO_SIZE = 16;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [CNT_W-1:0] pkt_count;
  logic             busy;

  // FIFO model controls
  logic             wr_en   = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             pl_en   = 1'b0;
  int               pl_n    = 0;
  logic [WIDTH-1:0] pl_data [FIFO_SIZE];
  logic [WIDTH-1:0] fmem    [FIFO_SIZE];
  int               fwp, frp, fcnt;
  logic             underflow;

  // Scoreboard and monitor state
  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] exp_q  [$];
  logic [WIDTH-1:0] last_q [$];
  int               cyc = 0;
  int               pop_cnt, rd_cnt, first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  int               outstanding, exp_beat, total_beats;
  logic [CNT_W-1:0] exp_pkt;
  logic             prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO with registered read data, plus a bulk preload used only while empty.
  always @(posedge clk or posedge reset) begin
    bit do_rd;
    bit do_wr;
    if (reset) begin
      fwp        <= 0;
      frp        <= 0;
      fcnt       <= 0;
      fifo_rdata <= '0;
      underflow  <= 1'b0;
    end else if (pl_en) begin
      for (int i = 0; i < FIFO_SIZE; i++)
        if (i < pl_n) fmem[i] <= pl_data[i];
      fwp  <= pl_n % FIFO_SIZE;
      frp  <= 0;
      fcnt <= pl_n;
    end else begin
      do_rd = fifo_rd_en && (fcnt != 0);
      do_wr = wr_en && (fcnt != FIFO_SIZE);
      if (fifo_rd_en && fcnt == 0) underflow <= 1'b1;
      if (do_rd) begin
        fifo_rdata <= fmem[frp];
        frp        <= (frp + 1) % FIFO_SIZE;
      end
      if (do_wr) begin
        fmem[fwp] <= wr_data;
        fwp       <= (fwp + 1) % FIFO_SIZE;
      end
      fcnt <= fcnt + (do_wr ? 1 : 0) - (do_rd ? 1 : 0);
    end
  end

  assign fifo_empty = (fcnt == 0);

  // Monitor on the falling edge: inputs are stable, so a beat seen here pops on the next rise.
  always @(negedge clk) begin
    logic             pop;
    logic [WIDTH-1:0] exp_d;
    if (reset) begin
      outstanding = 0;
      exp_beat    = 0;
      exp_pkt     = '0;
      prev_stall  = 1'b0;
      total_beats = 0;
    end else begin
      pop = m_valid && m_ready;

      n_checks++;
      if (busy !== (outstanding != 0)) begin
        n_errors++;
        $display("FAIL busy_track: busy=%0b outstanding=%0d", busy, outstanding);
      end
      n_checks++;
      if (pkt_count !== exp_pkt) begin
        n_errors++;
        $display("FAIL pkt_count_track: got %0d expected %0d", pkt_count, exp_pkt);
      end
      n_checks++;
      if (fifo_rd_en && fifo_empty) begin
        n_errors++;
        $display("FAIL read_while_empty: fifo_rd_en=1 with fifo_empty=1 at cycle %0d", cyc);
      end
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
          n_errors++;
          $display("FAIL stall_hold: valid=%0b data=%0h last=%0b expected valid=1 data=%0h last=%0b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end

      if (fifo_rd_en) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      if (pop) begin
        pop_cnt++;
        total_beats++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL beat_data: got unexpected %0h expected no beat", m_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (m_data !== exp_d) begin
            n_errors++;
            $display("FAIL beat_data: got %0h expected %0h", m_data, exp_d);
          end
        end
        n_checks++;
        if (m_last !== (exp_beat == PKT_LEN - 1)) begin
          n_errors++;
          $display("FAIL beat_last: got %0b expected %0b (data %0h)", m_last, (exp_beat == PKT_LEN - 1), m_data);
        end
        if (m_last) last_q.push_back(m_data);
        if (exp_beat == PKT_LEN - 1) begin
          exp_beat = 0;
          exp_pkt  = exp_pkt + 1'b1;
        end else begin
          exp_beat++;
        end
      end

      outstanding = outstanding + (fifo_rd_en ? 1 : 0) - (pop ? 1 : 0);
      n_checks++;
      if (outstanding > 2 || outstanding < 0) begin
        n_errors++;
        $display("FAIL occ_inflight_invariant: got %0d expected <= 2", outstanding);
      end

      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_counters();
    pop_cnt         = 0;
    rd_cnt          = 0;
    first_rd_cyc    = -1;
    first_valid_cyc = -1;
    first_pop_cyc   = -1;
    last_pop_cyc    = -1;
    last_q.delete();
  endtask

  task automatic preload(input logic [WIDTH-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      pl_data[i] = start + WIDTH'(i);
      exp_q.push_back(start + WIDTH'(i));
    end
    pl_n  = n;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pop_cnt < n; i++) tick();
    n_checks++;
    if (pop_cnt != n) begin
      n_errors++;
      $display("FAIL wait_pops_timeout: got %0d beats expected %0d", pop_cnt, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 ||
        pkt_count !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: rd_en=%0b valid=%0b data=%0h last=%0b pkt=%0d busy=%0b expected all 0",
               tag, fifo_rd_en, m_valid, m_data, m_last, pkt_count, busy);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    m_ready = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset_hold");
    reset = 1'b0;
    tick();
    preload(8'h11, 3);
    repeat (4) tick();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h11 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL pre_reset_state: valid=%0b data=%0h busy=%0b expected 1 11 1", m_valid, m_data, busy);
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    tick();
    reset = 1'b0;
    reset_counters();
    repeat (20) tick();
    n_checks++;
    if (rd_cnt != 0 || m_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: rd_en pulses=%0d valid=%0b expected 0 0", rd_cnt, m_valid);
    end
  endtask

  task automatic test_full_drain();
    logic [WIDTH-1:0] exp_last [4];
    exp_last = '{8'h04, 8'h08, 8'h0C, 8'h10};
    reset_counters();
    m_ready = 1'b1;
    preload(8'h01, 16);
    wait_pops(16, 60);
    repeat (2) tick();
    n_checks++;
    if (first_valid_cyc - first_rd_cyc != 2) begin
      n_errors++;
      $display("FAIL first_latency: got %0d expected 2", first_valid_cyc - first_rd_cyc);
    end
    n_checks++;
    if (last_pop_cyc - first_pop_cyc != 15) begin
      n_errors++;
      $display("FAIL drain_throughput: got span %0d expected 15", last_pop_cyc - first_pop_cyc);
    end
    n_checks++;
    if (last_q.size() != 4) begin
      n_errors++;
      $display("FAIL drain_last_count: got %0d expected 4", last_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (last_q[i] !== exp_last[i]) begin
          n_errors++;
          $display("FAIL drain_last_word: got %0h expected %0h", last_q[i], exp_last[i]);
        end
      end
    end
    n_checks++;
    if (pkt_count !== 16'd4 || fifo_empty !== 1'b1 || underflow !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_end: pkt=%0d empty=%0b underflow=%0b busy=%0b expected 4 1 0 0",
               pkt_count, fifo_empty, underflow, busy);
    end
  endtask

  task automatic test_backpressure();
    reset_counters();
    m_ready = 1'b0;
    preload(8'h01, 16);
    repeat (10) tick();
    n_checks++;
    if (rd_cnt != 2) begin
      n_errors++;
      $display("FAIL stall_reads: got %0d expected 2", rd_cnt);
    end
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h01 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_state: valid=%0b data=%0h busy=%0b expected 1 01 1", m_valid, m_data, busy);
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_rd_en !== 1'b1 || m_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL release_read: rd_en=%0b valid=%0b expected 1 1", fifo_rd_en, m_valid);
    end
    wait_pops(16, 60);
    repeat (2) tick();
    n_checks++;
    if (pkt_count !== 16'd8 || exp_q.size() != 0 || underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL backpressure_end: pkt=%0d pending=%0d underflow=%0b expected 8 0 0",
               pkt_count, exp_q.size(), underflow);
    end
  endtask

  task automatic test_partial_packet();
    int seen_valid;
    reset_counters();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_word(8'hA0 + WIDTH'(i));
    repeat (5) tick();
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid) seen_valid++;
    end
    n_checks++;
    if (seen_valid != 0 || pop_cnt != 6 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL pause_idle: valid cycles=%0d beats=%0d busy=%0b expected 0 6 0", seen_valid, pop_cnt, busy);
    end
    write_word(8'hA6);
    write_word(8'hA7);
    wait_pops(8, 40);
    n_checks++;
    if (last_q.size() != 2 || last_q[0] !== 8'hA3 || last_q[1] !== 8'hA7) begin
      n_errors++;
      $display("FAIL partial_last: got %0d last beats expected A3 and A7", last_q.size());
    end
    n_checks++;
    if (pkt_count !== 16'd10) begin
      n_errors++;
      $display("FAIL partial_pkt_count: got %0d expected 10", pkt_count);
    end
  endtask

  task automatic test_mid_packet_reset();
    reset_counters();
    m_ready = 1'b1;
    preload(8'h30, 16);
    wait_pops(2, 20);
    m_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_packet_reset");
    exp_q.delete();
    tick();
    reset = 1'b0;
    reset_counters();
    m_ready = 1'b1;
    preload(8'h50, 8);
    wait_pops(8, 40);
    n_checks++;
    if (last_q.size() != 2 || last_q[0] !== 8'h53 || last_q[1] !== 8'h57) begin
      n_errors++;
      $display("FAIL post_reset_framing: got %0d last beats expected 53 and 57", last_q.size());
    end
    n_checks++;
    if (pkt_count !== 16'd2) begin
      n_errors++;
      $display("FAIL post_reset_pkt_count: got %0d expected 2", pkt_count);
    end
  endtask

  task automatic test_random_stress();
    reset_counters();
    for (int c = 0; c < 2000; c++) begin
      wr_en = (fcnt < FIFO_SIZE) && ($urandom_range(0, 1) == 1);
      if (wr_en) begin
        wr_data = WIDTH'($urandom);
        exp_q.push_back(wr_data);
      end
      m_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    wr_en   = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    n_checks++;
    if (exp_q.size() != 0 || underflow !== 1'b0 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL stress_drain: pending=%0d underflow=%0b busy=%0b empty=%0b expected 0 0 0 1",
               exp_q.size(), underflow, busy, fifo_empty);
    end
    n_checks++;
    if (pkt_count !== CNT_W'(total_beats / PKT_LEN)) begin
      n_errors++;
      $display("FAIL stress_pkt_count: got %0d expected %0d", pkt_count, total_beats / PKT_LEN);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_counters();
    test_reset();
    test_full_drain();
    test_backpressure();
    test_partial_packet();
    test_mid_packet_reset();
    test_random_stress();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain stage that sits directly downstream of the synchronous FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle read latency in a 2-entry output buffer, and presents the data as a valid/ready stream framed into fixed-length packets (`m_last` on every `PKT_LEN`-th beat). It never reads an empty FIFO. It sustains one word per clock when the consumer holds `m_ready` high.

## Interface
- `WIDTH`, 8: data width; must match the FIFO's `WIDTH`.
- `PKT_LEN`, 4: beats per packet, ≥1; `m_last` marks beat `PKT_LEN-1`.
- `CNT_W`, 16: width of `pkt_count`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_rdata`  in  WIDTH  FIFO `rdata`; valid the cycle after `fifo_rd_en` is sampled high.
- `fifo_rd_en`  out  1  FIFO read strobe, driven to the FIFO's `rd_en`.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  consumer accepts the word this cycle.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  final beat of a packet; qualified by `m_valid`.
- `pkt_count`  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.
- `busy`  out  1  high when the buffer is non-empty or a read is in flight.

## Operation
- State:
  - `occ` (0..2): buffer entries.
  - `inflight` (1 bit): `fifo_rd_en` delayed by one cycle.
  - `beat` (0..PKT_LEN-1): packet position.
  - `pkt_count`.
- A pop occurs when `m_valid && m_ready`.
- `fifo_rd_en = !reset && !fifo_empty && (occ + inflight - pop) < 2`.
  - This is a combinational path from `m_ready`; it is required for full throughput.
- Each rising edge with `inflight=1`: capture `fifo_rdata` at the buffer tail.
- Each pop: advance the head.
- Push and pop in the same cycle: `occ` is unchanged and data order is preserved.
- Invariant: `occ + inflight ≤ 2` at all times. Violation is a design error; the bench asserts it.
- `m_valid = (occ != 0)`. `m_data` is the head entry. `m_last = (beat == PKT_LEN-1)`.
- On each pop:
  - `beat` increments, wrapping to 0 after `PKT_LEN-1`.
  - If `m_last`, `pkt_count` increments.
- `busy = (occ != 0) || inflight`.
- Stream rules:
  - Once `m_valid` is high, it stays high until the pop.
  - `m_data` and `m_last` are stable while `m_valid && !m_ready`.
- Empty FIFO: `fifo_rd_en` stays 0. The block never causes FIFO `underflow`.
- Partial packet with the FIFO drained: `m_valid` falls and `beat` holds. The packet resumes when data arrives; there is no timeout.
- Reset (asynchronous, may occur mid-packet):
  - Clears `occ`, `inflight`, `beat`, `pkt_count`.
  - Buffered words are discarded.
  - The FIFO is reset by the same `reset`.

## Timing
- Reset values: `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `m_last=0` (`PKT_LEN=1` gives `m_last=1`, masked by `m_valid=0`), `pkt_count=0`, `busy=0`.
- Latency:
  - `fifo_rd_en` is sampled high at edge E.
  - `fifo_rdata` is valid after E.
  - The word is captured at E+1 and `m_valid` is high after E+1.
  - Total: 2 clocks from the read edge to output valid.
- First word: `fifo_rd_en` rises in the same cycle `fifo_empty` is low (combinational).
- Throughput: with `m_ready=1` and a non-empty FIFO, one read and one pop per clock; `occ` settles at 1.
- Backpressure:
  - With `m_ready=0`, at most 2 reads are issued after the stall begins. `fifo_rd_en` then stays low.
  - After `m_ready` rises, the first pop happens in that cycle. `fifo_rd_en` re-asserts in the same cycle.
- `pkt_count` updates on the edge that completes the `m_last` pop.

## Test plan
- Reset check: assert `reset` asynchronously between edges -> all outputs are at reset values immediately, and after release with the FIFO empty, `fifo_rd_en` never asserts over 20 cycles.
- Full-drain throughput: preload the FIFO with 16 words `0x01..0x10`, `m_ready=1` -> 16 consecutive beats `0x01..0x10`, first `m_valid` 2 clocks after the first read, `m_last` on `0x04`, `0x08`, `0x0C`, `0x10`, `pkt_count=4`, FIFO `empty=1` and `underflow=0`.
- Backpressure: 16 words preloaded, `m_ready=0` for 10 cycles -> exactly 2 `fifo_rd_en` pulses, `m_data=0x01` held stable, `busy=1`; after release, `0x01..0x10` with no loss or duplication.
- Partial packet stall: write 6 words `0xA0..0xA5`, then pause 15 cycles, then write `0xA6..0xA7` -> `m_last` on `0xA3` and `0xA7`, `m_valid` low during the pause, `pkt_count=2`.
- Random stress: random FIFO writes (≤ `FIFO_SIZE`, full-respecting) plus 50% random `m_ready` for 2000 cycles -> scoreboard order match, invariant `occ+inflight≤2` holds, `underflow` never set, `pkt_count` = completed beats / `PKT_LEN`.
- Mid-packet reset: reset after beats 1–2 of a packet -> outputs clear, `pkt_count=0`; after refill, `m_last` falls on the 4th post-reset beat.
